// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default geometry for the 16-bit single-port memory
//
// Provides the burst sequencer state encoding and the default word/address
// widths that the memory and its masters agree on.

package mem_pkg;

    localparam int MEM_WIDTH      = 16;
    localparam int MEM_ADDR_WIDTH = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RHOLD = 3'd4
    } mem_burst_state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// rtl/mem_timeout_cnt.sv - per-beat watchdog for the memory acknowledge
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset
//   clear_i    restart the count (takes priority over en_i)
//   en_i       count this cycle (high while waiting for the memory)
//   expired_o  high during the TIMEOUT-th enabled cycle since the last clear

module mem_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of enabled cycles already elapsed, so the
    // TIMEOUT-th waiting cycle is the one that sees LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_burst_master.sv
// rtl/mem_burst_master.sv - burst request sequencer for the 16-bit single-port memory
//
// Accepts one burst command, then issues one memory access per beat. Write
// beats are pulled from the wd_* stream, read beats are pushed out on the
// rd_* stream with unbounded back-pressure. A watchdog aborts the burst when
// the memory does not acknowledge a beat within TIMEOUT waiting cycles.
//
// Ports:
//   clk_i, rst_i                         clock / async active-high reset
//   cmd_valid_i, cmd_ready_o             command handshake (ready only in IDLE)
//   cmd_wr_i, cmd_addr_i, cmd_len_i      direction, first word, beats-1
//   wd_valid_i, wd_data_i, wd_ready_o    write-data stream
//   rd_valid_o, rd_data_o, rd_ready_i    read-data stream
//   busy_o, done_o, err_o                activity, completion pulse, abort pulse
//   mem_valid_o, mem_wr_rd_o,
//   mem_addr_o, mem_wdata_o              memory request side
//   mem_rdata_i, mem_ready_i             memory response side

module mem_burst_master
    import mem_pkg::*;
#(
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int LEN_WIDTH  = 9,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wd_valid_i,
    input  logic [WIDTH-1:0]      wd_data_i,
    output logic                  wd_ready_o,
    output logic                  rd_valid_o,
    output logic [WIDTH-1:0]      rd_data_o,
    input  logic                  rd_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  mem_valid_o,
    output logic                  mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0]      mem_wdata_o,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    input  logic                  mem_ready_i
);

    mem_burst_state_e      state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic                  wr_q, wr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic wdog_clear;
    logic wdog_expired;
    logic last_beat;

    assign last_beat = (beat_q == len_q);

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (wdog_clear),
        .en_i      (state_q == ST_WAIT),
        .expired_o (wdog_expired)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wdog_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    len_d   = cmd_len_i;
                    wr_d    = cmd_wr_i;
                    beat_d  = '0;
                    state_d = cmd_wr_i ? ST_WDATA : ST_ISSUE;
                end
            end
            ST_WDATA: begin
                if (wd_valid_i) begin
                    wdata_d = wd_data_i;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wdog_clear = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // An acknowledge in the final watchdog cycle still counts.
                if (mem_ready_i) begin
                    if (!wr_q) begin
                        rdata_d  = mem_rdata_i;
                        rvalid_d = 1'b1;
                        state_d  = ST_RHOLD;
                    end else if (last_beat) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        beat_d  = beat_q + 1'b1;
                        state_d = ST_WDATA;
                    end
                end else if (wdog_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RHOLD: begin
                if (rd_ready_i) begin
                    rvalid_d = 1'b0;
                    if (last_beat) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        beat_d  = beat_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign wd_ready_o  = (state_q == ST_WDATA);
    assign mem_valid_o = (state_q == ST_ISSUE);
    assign busy_o      = (state_q != ST_IDLE);
    assign rd_valid_o  = rvalid_q;
    assign rd_data_o   = rdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign mem_wr_rd_o = wr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_burst_master.sv
// tb/tb_mem_burst_master.sv - self-checking bench for mem_burst_master

module tb_mem_burst_master;

    localparam int W  = 16;
    localparam int AW = 9;
    localparam int LW = 9;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_wr_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [LW-1:0] cmd_len_i = '0;
    logic          wd_valid_i = 1'b0;
    logic [W-1:0]  wd_data_i = '0;
    logic          wd_ready_o;
    logic          rd_valid_o;
    logic [W-1:0]  rd_data_o;
    logic          rd_ready_i = 1'b1;
    logic          busy_o, done_o, err_o;
    logic          mem_valid_o, mem_wr_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [W-1:0]  mem_wdata_o;
    logic [W-1:0]  mem_rdata_i;
    logic          mem_ready_i;

    mem_burst_master #(.WIDTH(W), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .wd_valid_i(wd_valid_i), .wd_data_i(wd_data_i), .wd_ready_o(wd_ready_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- memory device (registered ready one edge after valid)
    logic [W-1:0] mem_arr [512];
    logic         mem_inited = 1'b0;
    logic         r0 = 1'b0, r1 = 1'b0;
    logic         mem_stuck = 1'b0, mem_stale = 1'b0;
    logic [W-1:0] rdata_r = '0;

    always @(posedge clk_i) begin
        if (!mem_inited) begin
            for (int i = 0; i < 512; i++) mem_arr[i] <= W'(i) ^ 16'h5A00;
            mem_inited <= 1'b1;
        end else if (mem_valid_o) begin
            if (mem_wr_rd_o) mem_arr[mem_addr_o] <= mem_wdata_o;
            rdata_r <= mem_arr[mem_addr_o];
        end
        r0 <= mem_valid_o && !mem_stuck;
        r1 <= r0;
    end
    assign mem_ready_i = r0 || (mem_stale && r1);
    assign mem_rdata_i = rdata_r;

    // ---------------- reference model state
    int tests = 0, fails = 0, cyc = 0;
    logic [W-1:0] ref_mem [512];
    int qa[$], qw[$], qd[$], rdq[$];
    logic [W-1:0] wq[$];
    int addr_log[$], rd_log[$], issue_log[$];
    int exp_mode = 0;   // 0 nothing, 1 done expected, 2 err expected
    int done_seen = 0, err_seen = 0, acc_cyc = 0, done_cyc = 0, err_cyc = 0;
    int stall_beat = -1, stall_left = 0, acc_cnt = 0, rv_cycles = 0;
    logic prev_hold = 1'b0, prev_mv = 1'b0;
    logic [W-1:0] prev_rd = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- stream drivers and per-cycle compare
    always @(negedge clk_i) begin
        cyc++;
        if (rst_i) begin
            prev_hold  = 1'b0;
            prev_mv    = 1'b0;
            rd_ready_i = 1'b1;
            wd_valid_i = 1'b0;
        end else begin
            rd_ready_i = !(acc_cnt == stall_beat && stall_left > 0);
            wd_valid_i = (wq.size() > 0);
            wd_data_i  = (wq.size() > 0) ? wq[0] : '0;
            chk("busy_vs_cmd_ready", busy_o, !cmd_ready_o);
            if (prev_hold) begin
                chk("rd_valid_held", rd_valid_o, 1);
                chk("rd_data_held", rd_data_o, prev_rd);
            end
            if (cmd_valid_i && cmd_ready_o) acc_cyc = cyc;
            if (mem_valid_o) begin
                chk("mem_valid_single_cycle", prev_mv, 0);
                chk("mem_valid_while_rd_valid", rd_valid_o, 0);
                chk("mem_access_pending", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    chk("mem_addr", mem_addr_o, qa.pop_front());
                    chk("mem_wr_rd", mem_wr_rd_o, qw.pop_front());
                    if (mem_wr_rd_o) chk("mem_wdata", mem_wdata_o, qd[0]);
                    void'(qd.pop_front());
                end
                addr_log.push_back(int'(mem_addr_o));
                issue_log.push_back(cyc);
            end
            prev_mv = mem_valid_o;
            if (rd_valid_o) rv_cycles++;
            if (rd_valid_o && rd_ready_i) begin
                chk("rd_beat_pending", rdq.size() > 0, 1);
                if (rdq.size() > 0) chk("rd_data", rd_data_o, rdq.pop_front());
                rd_log.push_back(int'(rd_data_o));
                acc_cnt++;
            end
            if (rd_valid_o && !rd_ready_i && stall_left > 0) stall_left--;
            prev_hold = rd_valid_o && !rd_ready_i;
            prev_rd   = rd_data_o;
            if (wd_ready_o && wd_valid_i) void'(wq.pop_front());
            if (done_o) begin
                chk("done_expected", exp_mode, 1);
                chk("done_queues_empty", qa.size() + rdq.size(), 0);
                chk("done_err_exclusive", err_o, 0);
                exp_mode = 0;
                done_seen++;
                done_cyc = cyc;
            end
            if (err_o) begin
                chk("err_expected", exp_mode, 2);
                exp_mode = 0;
                err_seen++;
                err_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic start_cmd(input logic wr, input int addr, input int len,
                             input logic [W-1:0] dbase, input int mode);
        logic [AW-1:0] a;
        int n;
        for (int i = 0; i <= len; i++) begin
            a = AW'(addr + i);
            qa.push_back(int'(a));
            qw.push_back(int'(wr));
            qd.push_back(wr ? int'(dbase + W'(i)) : 0);
            if (wr) begin
                ref_mem[a] = dbase + W'(i);
                wq.push_back(dbase + W'(i));
            end else begin
                rdq.push_back(int'(ref_mem[a]));
            end
        end
        exp_mode = mode;
        addr_log.delete();
        rd_log.delete();
        issue_log.delete();
        n = 0;
        @(posedge clk_i); #1;
        while (!cmd_ready_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("cmd_ready_within_budget", cmd_ready_o, 1);
        cmd_wr_i    = wr;
        cmd_addr_i  = AW'(addr);
        cmd_len_i   = LW'(len);
        cmd_valid_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int s, n;
        s = done_seen;
        n = 0;
        while (done_seen == s && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("done_within_budget", done_seen != s, 1);
    endtask

    task automatic flush_model();
        qa.delete(); qw.delete(); qd.delete(); rdq.delete(); wq.delete();
        exp_mode = 0;
    endtask

    // ---------------- directed sequence
    initial begin
        int exp4 [4];
        int s_done, s_err, n;

        for (int i = 0; i < 512; i++) ref_mem[i] = W'(i) ^ 16'h5A00;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_wd_ready", wd_ready_o, 0);
        chk("rst_done_err", {done_o, err_o}, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        rst_i = 1'b0;

        // 1: write burst 0x010 len 3, stale ready in the following cycle
        mem_stale = 1'b1;
        start_cmd(1'b1, 'h010, 3, 16'h00A0, 1);
        wait_done(200);
        exp4 = '{'h010, 'h011, 'h012, 'h013};
        chk("t1_beats", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t1_addr", addr_log[i], exp4[i]);
        chk("t1_mem_013", mem_arr[9'h013], 16'h00A3);
        chk("t1_latency", done_cyc - acc_cyc, 13);

        // 2: read back with rd_ready tied high
        start_cmd(1'b0, 'h010, 3, '0, 1);
        wait_done(200);
        exp4 = '{'h00A0, 'h00A1, 'h00A2, 'h00A3};
        chk("t2_beats", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("t2_rdata", rd_log[i], exp4[i]);
        chk("t2_latency", done_cyc - acc_cyc, 13);
        mem_stale = 1'b0;

        // 3: address wrap
        start_cmd(1'b0, 'h1FE, 3, '0, 1);
        wait_done(200);
        exp4 = '{'h1FE, 'h1FF, 'h000, 'h001};
        chk("t3_beats", addr_log.size(), 4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t3_addr", addr_log[i], exp4[i]);
        exp4 = '{'h5BFE, 'h5BFF, 'h5A00, 'h5A01};
        for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("t3_rdata", rd_log[i], exp4[i]);

        // 4: consumer stalls beat 1 for 10 cycles
        s_err = err_seen;
        acc_cnt = 0; stall_beat = 1; stall_left = 10; rv_cycles = 0;
        start_cmd(1'b0, 'h010, 3, '0, 1);
        wait_done(300);
        chk("t4_rv_cycles", rv_cycles, 14);
        chk("t4_latency", done_cyc - acc_cyc, 23);
        chk("t4_no_err", err_seen, s_err);
        stall_beat = -1;

        // 5: memory never answers -> abort, then a normal burst
        mem_stuck = 1'b1;
        s_done = done_seen;
        s_err  = err_seen;
        start_cmd(1'b0, 'h020, 2, '0, 2);
        n = 0;
        while (err_seen == s_err && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("t5_err_seen", err_seen - s_err, 1);
        if (issue_log.size() > 0) chk("t5_err_timing", err_cyc - issue_log[0], 16);
        chk("t5_issues", issue_log.size(), 1);
        chk("t5_cmd_ready", cmd_ready_o, 1);
        chk("t5_no_done", done_seen, s_done);
        flush_model();
        mem_stuck = 1'b0;
        start_cmd(1'b0, 'h020, 2, '0, 1);
        wait_done(200);
        chk("t5_after_beats", rd_log.size(), 3);
        if (rd_log.size() == 3) chk("t5_after_last", rd_log[2], 'h5A22);

        // 6: asynchronous reset while a write beat waits
        mem_stuck = 1'b1;
        s_done = done_seen;
        s_err  = err_seen;
        start_cmd(1'b1, 'h030, 1, 16'h00B0, 0);
        n = 0;
        while (addr_log.size() == 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        chk("t6_issued", addr_log.size(), 1);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t6_busy_before_rst", busy_o, 1);
        rst_i = 1'b1;
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_cmd_ready", cmd_ready_o, 1);
        chk("t6_strobes", {wd_ready_o, mem_valid_o, rd_valid_o, done_o, err_o}, 0);
        chk("t6_mem_wr_rd", mem_wr_rd_o, 0);
        chk("t6_mem_addr", mem_addr_o, 0);
        chk("t6_mem_wdata", mem_wdata_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        flush_model();
        ref_mem[9'h031] = 16'h5A31;
        mem_stuck = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("t6_no_done", done_seen, s_done);
        chk("t6_no_err", err_seen, s_err);
        start_cmd(1'b0, 'h010, 0, '0, 1);
        wait_done(100);
        chk("t6_after_beats", rd_log.size(), 1);
        if (rd_log.size() == 1) chk("t6_after_rdata", rd_log[0], 'h00A0);

        // 7: single-beat write at the top word, then a maximum-length read
        start_cmd(1'b1, 'h1FF, 0, 16'h00C0, 1);
        wait_done(100);
        chk("t7_mem_1ff", mem_arr[9'h1FF], 16'h00C0);
        start_cmd(1'b0, 'h000, 511, '0, 1);
        wait_done(2000);
        chk("t7_beats", rd_log.size(), 512);
        chk("t7_latency", done_cyc - acc_cyc, 1537);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
